fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Fetch front end placed between the instruction ROM and the decode/rename/dispatch path.
- Owns the program counter and walks it through the packed instruction ROM.
- Buffers fetched words in a small FIFO, so backpressure from decode, rename, RS, ROB or LSQ stalls fetch without losing instructions.
- Raises fetch_complete only when every ROM instruction has been fetched and handed downstream.

Parameters:
- ROM_WORDS, 256, number of 32-bit instruction slots in instr_rom.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- instr_rom  input  ROM_WORDS*32  packed ROM; word k at bits [k*32 +: 32].
- rom_size  input  32  program length in bytes.
- out_ready  input  1  downstream can accept an instruction this cycle.
- out_valid  output  1  head entry holds a valid instruction.
- out_instr  output  32  head instruction word.
- out_pc  output  32  byte PC of the head instruction.
- occupancy  output  PTR_W+1  number of valid FIFO entries.
- fetch_complete  output  1  all instructions fetched and drained.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port reset.
- Reset state:
  - pc=0, head=tail=0, occupancy=0.
  - out_valid=0, out_instr=0, out_pc=0.
  - fetch_complete=0 (combinational from state, so reset gives 0 unless limit=0, see below).
- Fetch limit: limit = min(rom_size, ROM_WORDS*4). A rom_size that is not a multiple of 4 is treated as a byte bound: fetch continues while pc < limit.
- Push:
  - Condition: pc < limit, and either occupancy < DEPTH or a pop happens in the same cycle.
  - Action: write {instr_rom[pc[PTR..]*32 +: 32], pc} into FIFO[tail]; then tail+=1 (wraps modulo DEPTH) and pc+=4.
  - Word index is pc[31:2]; indexes at or above ROM_WORDS are never read because of the limit.
- Pop:
  - Condition: out_valid && out_ready.
  - Action: head+=1 (wraps modulo DEPTH).
- Head outputs:
  - out_instr and out_pc are driven combinationally from FIFO[head].
  - out_valid = (occupancy != 0).
  - Outputs are held stable while out_valid && !out_ready.
- Occupancy per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Latency: an instruction pushed at edge N appears at the head, if the FIFO was empty, in the cycle after edge N. The first instruction is valid one cycle after reset deasserts. There is no combinational path from out_ready to out_valid.
- Full: with occupancy==DEPTH and out_ready=0, pc holds and no ROM read is committed. With occupancy==DEPTH and out_ready=1, push and pop happen in the same cycle.
- Empty: with occupancy==0, out_valid=0 and out_ready is ignored. out_instr and out_pc are don't-care but must not produce X after reset.
- fetch_complete = (pc >= limit) && (occupancy==0). It is combinational from registered state and stays high until reset. limit=0 gives fetch_complete=1 immediately after reset.
- rom_size changing mid-run: the new limit is re-evaluated every cycle. Entries already queued are still delivered.
- Reset mid-operation: queued entries are discarded, pc returns to 0, and outputs go to their reset values asynchronously.
- State machine, derived from pc and occupancy:
  - FETCHING: pc < limit.
  - DRAINING: pc >= limit and occupancy > 0.
  - DONE: pc >= limit and occupancy == 0.
  - Transitions are monotonic FETCHING -> DRAINING -> DONE. Only reset returns to FETCHING.

Decomposition:
- Shared package: constant INSTR_W=32, constant PC_STEP=4, and the ROM_WORDS default, shared with the top-level ROM loader.
- Sub-module sync_fifo (parameters WIDTH=64, DEPTH): holds the {pc, instr} entries.
- fetch_queue keeps the pc, the limit and completion logic, and the ROM word select.

Test Plan:
- Sequential pass-through: ROM words 0x00500093, 0x00A00113, 0x002081B3; rom_size=12; out_ready=1 throughout. Required: out_valid from cycle 1; out_pc 0, 4, 8 on consecutive cycles with matching words; fetch_complete rises in cycle 4 and stays high.
- Backpressure fill: 8-word ROM, rom_size=32, out_ready=0 for 10 cycles. Required: occupancy saturates at 4; pc holds at 16; out_pc stays 0 and out_instr stays word 0 throughout. Then out_ready=1: pcs 0..28 delivered in order with no gaps or duplicates.
- Full with simultaneous push and pop: occupancy=4 and out_ready=1 for one cycle. Required: occupancy stays 4; head advances by one; tail wraps from index 3 to 0 correctly.
- Boundary sizes:
  - rom_size=0: fetch_complete=1 and out_valid=0 right after reset.
  - rom_size=6: exactly 2 instructions delivered (pc 0 and 4).
  - rom_size=2000 with ROM_WORDS=256: fetching stops at pc=1024.
- Reset mid-operation: pulse reset low while occupancy=3 and pc=20. Required: out_valid=0 and occupancy=0 asynchronously, before the next edge. After release, delivery restarts at pc 0.
- Randomised out_ready, 50% duty, on a 64-word ROM: the scoreboard sees 64 in-order instructions, and fetch_complete is never asserted before the last pop.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch constants and completion-state encoding.
package fetch_queue_pkg;

    localparam int INSTR_W       = 32;
    localparam int PC_STEP       = 4;
    localparam int ROM_WORDS_DEF = 256;

    typedef enum logic [1:0] {FETCHING, DRAINING, DONE} fq_state_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: power-of-two circular buffer with same-cycle push/pop when full.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head, tail;

    // Storage is cleared too, so the head word is never X when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= din;
                tail      <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    assign dout  = mem[head];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: walks the pc through the packed instruction ROM into a small FIFO
// and reports completion once every word has been fetched and handed downstream.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int ROM_WORDS = ROM_WORDS_DEF,
    parameter int DEPTH     = 4,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ROM_WORDS*INSTR_W-1:0]   instr_rom,
    input  logic [31:0]                    rom_size,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [INSTR_W-1:0]             out_instr,
    output logic [31:0]                    out_pc,
    output logic [PTR_W:0]                 occupancy,
    output logic                           fetch_complete
);

    localparam int          AW        = $clog2(ROM_WORDS);
    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * PC_STEP);

    logic [31:0]         pc, limit;
    logic                push, pop, full, empty;
    logic [AW-1:0]       word_idx;
    logic [INSTR_W-1:0]  rom_word;
    logic [31+INSTR_W:0] head_entry;
    fq_state_t           state;

    // A pop frees a slot in the same cycle, so a full queue keeps streaming.
    always_comb begin
        limit          = (rom_size < ROM_BYTES) ? rom_size : ROM_BYTES;
        word_idx       = pc[AW+1:2];
        rom_word       = instr_rom[INSTR_W*int'(word_idx) +: INSTR_W];
        pop            = out_valid && out_ready;
        push           = (pc < limit) && (!full || pop);
        state          = (pc < limit) ? FETCHING : (empty ? DONE : DRAINING);
        fetch_complete = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else if (push) pc <= pc + 32'(PC_STEP);
    end

    sync_fifo #(
        .WIDTH(32 + INSTR_W),
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  ({pc, rom_word}),
        .dout (head_entry),
        .count(occupancy),
        .full (full),
        .empty(empty)
    );

    assign {out_pc, out_instr} = head_entry;
    assign out_valid = !empty;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenario tasks for fetch_queue with inline expected values.
module tb_fetch_queue;

    localparam int RW = 256;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [RW*32-1:0] instr_rom = '0;
    logic [31:0]     rom_size = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [31:0]     out_instr;
    logic [31:0]     out_pc;
    logic [2:0]      occupancy;
    logic            fetch_complete;

    logic [31:0] rom_w [RW];
    int checks = 0;
    int errors = 0;

    fetch_queue #(.ROM_WORDS(RW), .DEPTH(4), .PTR_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_rom     (instr_rom),
        .rom_size      (rom_size),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .occupancy     (occupancy),
        .fetch_complete(fetch_complete)
    );

    always #5 clk = ~clk;

    task automatic load_rom(input logic [31:0] base);
        for (int k = 0; k < RW; k++) begin
            rom_w[k] = base + 32'(k);
            instr_rom[k*32 +: 32] = rom_w[k];
        end
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops under 'rnd' or constant ready until completion; reports count and ordering.
    task automatic collect(input int start, input int max_cycles, input bit rnd,
                           output int n, output bit in_order);
        n = start;
        in_order = 1'b1;
        for (int c = 0; c < max_cycles && !fetch_complete; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (out_pc !== 32'(n*4) || out_instr !== rom_w[n]) in_order = 1'b0;
                n++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        load_rom(32'h1000_0000);
        rom_size = 32'd12;
        reset = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
        if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", out_instr); end
        if (fetch_complete !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", fetch_complete); end
    endtask

    task automatic test_pass_through();
        load_rom(32'h0);
        rom_w[0] = 32'h0050_0093; rom_w[1] = 32'h00A0_0113; rom_w[2] = 32'h0020_81B3;
        for (int k = 0; k < 3; k++) instr_rom[k*32 +: 32] = rom_w[k];
        rom_size = 32'd12;
        out_ready = 1'b1;
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            step();
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL pt_valid[%0d] got %0b want 1", k, out_valid); end
            if (out_pc !== 32'(k*4)) begin errors++; $display("FAIL pt_pc[%0d] got %h want %h", k, out_pc, k*4); end
            if (out_instr !== rom_w[k]) begin errors++; $display("FAIL pt_instr[%0d] got %h want %h", k, out_instr, rom_w[k]); end
            if (fetch_complete !== 1'b0) begin errors++; $display("FAIL pt_early_done[%0d] got %0b want 0", k, fetch_complete); end
        end
        for (int k = 0; k < 2; k++) begin
            step();
            checks += 2;
            if (fetch_complete !== 1'b1) begin errors++; $display("FAIL pt_done[%0d] got %0b want 1", k, fetch_complete); end
            if (out_valid !== 1'b0) begin errors++; $display("FAIL pt_empty[%0d] got %0b want 0", k, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit ok;
        load_rom(32'hC0DE_0000);
        rom_size = 32'd32;
        out_ready = 1'b0;
        reset_dut();
        for (int c = 1; c <= 10; c++) begin
            step();
            checks += 3;
            if (occupancy !== 3'(c < 4 ? c : 4)) begin errors++; $display("FAIL bp_occ[%0d] got %0d want %0d", c, occupancy, c < 4 ? c : 4); end
            if (out_pc !== 32'd0) begin errors++; $display("FAIL bp_pc[%0d] got %h want 0", c, out_pc); end
            if (out_instr !== rom_w[0]) begin errors++; $display("FAIL bp_instr[%0d] got %h want %h", c, out_instr, rom_w[0]); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks += 3;
        if (occupancy !== 3'd4) begin errors++; $display("FAIL full_pp_occ got %0d want 4", occupancy); end
        if (out_pc !== 32'd4) begin errors++; $display("FAIL full_pp_pc got %h want 4", out_pc); end
        if (out_instr !== rom_w[1]) begin errors++; $display("FAIL full_pp_instr got %h want %h", out_instr, rom_w[1]); end
        step();
        checks += 1;
        if (out_pc !== 32'd4) begin errors++; $display("FAIL full_hold_pc got %h want 4", out_pc); end
        collect(1, 40, 1'b0, n, ok);
        checks += 3;
        if (n !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", n); end
        if (!ok) begin errors++; $display("FAIL bp_order got out_of_order want in_order"); end
        if (fetch_complete !== 1'b1) begin errors++; $display("FAIL bp_done got %0b want 1", fetch_complete); end
    endtask

    task automatic test_boundary();
        int n;
        bit ok;
        load_rom(32'hB000_0000);
        rom_size = 32'd0;
        out_ready = 1'b1;
        reset = 1'b0;
        #1;
        checks += 1;
        if (fetch_complete !== 1'b1) begin errors++; $display("FAIL size0_done_in_reset got %0b want 1", fetch_complete); end
        reset_dut();
        step();
        checks += 2;
        if (fetch_complete !== 1'b1) begin errors++; $display("FAIL size0_done got %0b want 1", fetch_complete); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL size0_valid got %0b want 0", out_valid); end
        rom_size = 32'd6;
        reset_dut();
        step();
        collect(0, 20, 1'b0, n, ok);
        checks += 2;
        if (n !== 2) begin errors++; $display("FAIL size6_count got %0d want 2", n); end
        if (!ok) begin errors++; $display("FAIL size6_order got out_of_order want in_order"); end
        rom_size = 32'd2000;
        reset_dut();
        step();
        collect(0, 300, 1'b0, n, ok);
        checks += 3;
        if (n !== 256) begin errors++; $display("FAIL size2000_count got %0d want 256", n); end
        if (!ok) begin errors++; $display("FAIL size2000_order got out_of_order want in_order"); end
        if (fetch_complete !== 1'b1) begin errors++; $display("FAIL size2000_done got %0b want 1", fetch_complete); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        load_rom(32'hD000_0000);
        rom_size = 32'd64;
        out_ready = 1'b0;
        reset_dut();
        step(); step();
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
        step();
        checks += 2;
        if (occupancy !== 3'd3) begin errors++; $display("FAIL mid_occ_pre got %0d want 3", occupancy); end
        if (out_pc !== 32'd8) begin errors++; $display("FAIL mid_pc_pre got %h want 8", out_pc); end
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %0b want 0", out_valid); end
        if (occupancy !== 3'd0) begin errors++; $display("FAIL mid_async_occ got %0d want 0", occupancy); end
        if (out_pc !== 32'd0) begin errors++; $display("FAIL mid_async_pc got %h want 0", out_pc); end
        reset_dut();
        step();
        collect(0, 40, 1'b0, n, ok);
        checks += 2;
        if (n !== 16) begin errors++; $display("FAIL mid_count got %0d want 16", n); end
        if (!ok) begin errors++; $display("FAIL mid_order got out_of_order want in_order"); end
    endtask

    task automatic test_random_ready();
        int n;
        bit ok;
        load_rom(32'hE000_0000);
        rom_size = 32'd256;
        out_ready = 1'b0;
        reset_dut();
        step();
        collect(0, 600, 1'b1, n, ok);
        checks += 2;
        if (n !== 64) begin errors++; $display("FAIL rnd_count got %0d want 64", n); end
        if (!ok) begin errors++; $display("FAIL rnd_order got out_of_order want in_order"); end
        for (int c = 0; c < 3; c++) begin
            out_ready = 1'(c & 1);
            step();
            checks += 1;
            if (fetch_complete !== 1'b1) begin errors++; $display("FAIL rnd_done_sticky[%0d] got %0b want 1", c, fetch_complete); end
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        test_random_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
